// File: rtl/aptag_pkg.sv
// Shared constants, scan state encoding and saturating add for the APT address generator.
package aptag_pkg;

    localparam int W = 16;
    localparam int B = 8;

    typedef enum logic {
        ST_DONE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

    // Sum is carried in W+1 bits; anything that reaches bit W clamps to all-ones.
    function automatic logic [W-1:0] sat_add(input logic [W:0] li, input logic [B-1:0] idx);
        logic [W:0] sum;
        sum = li + (W+1)'(idx);
        return sum[W] ? {W{1'b1}} : sum[W-1:0];
    endfunction

endpackage

// File: rtl/aptag_case1_if.sv
// Decoder-side bundle for the APT address generator: match vector in, APT address out.
interface aptag_case1_if #(
    parameter int w = 16,
    parameter int b = 8
);
    logic                en;
    logic [w:0]          LI;
    logic [0:(1<<b)-1]   data;
    logic [b-1:0]        IBPI;
    logic [w-1:0]        APTA;

    modport master (
        output en,
        output LI,
        output data,
        output IBPI,
        input  APTA
    );

    modport slave (
        input  en,
        input  LI,
        input  data,
        input  IBPI,
        output APTA
    );
endinterface

// File: rtl/aptag_penc.sv
// Masked priority encoder: lowest set index of vec within [lo, hi], data[0] is the leftmost bit.
module aptag_penc #(
    parameter int b = 8
) (
    input  logic [0:(1<<b)-1] vec,
    input  logic [b:0]        lo,
    input  logic [b-1:0]      hi,
    output logic              hit,
    output logic [b-1:0]      idx
);
    localparam int N = 1 << b;

    // Walk downward so the lowest qualifying index is the last one written.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i] && (i >= int'(lo)) && (i <= int'(hi))) begin
                hit = 1'b1;
                idx = i[b-1:0];
            end
        end
    end
endmodule

// File: rtl/aptag_case1.sv
// APT address generator, case 1: one saturated LI+index address per set bit in data[0..IBPI].
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_DONE | no scan in progress; APTA holds, waits for an en rising edge
// ST_SCAN | scan active; each enabled cycle emits the next set position
module aptag_case1
    import aptag_pkg::*;
#(
    parameter int w = W,
    parameter int b = B
) (
    input  logic          clk,
    input  logic          rst,
    aptag_case1_if.slave  bus
);
    scan_state_t  state, state_nxt;
    logic         en_q;
    logic         start;
    logic [b:0]   ptr, ptr_nxt;
    logic [b:0]   lo;
    logic [w-1:0] apta, apta_nxt;
    logic         hit;
    logic [b-1:0] idx;
    logic [w:0]   sum;
    logic [w-1:0] sat;

    assign start = bus.en & ~en_q;
    assign lo    = start ? '0 : ptr;

    aptag_penc #(.b(b)) u_penc (
        .vec (bus.data),
        .lo  (lo),
        .hi  (bus.IBPI),
        .hit (hit),
        .idx (idx)
    );

    assign sum = bus.LI + (w+1)'(idx);
    assign sat = sum[w] ? {w{1'b1}} : sum[w-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_DONE;
            en_q  <= 1'b0;
            ptr   <= '0;
            apta  <= '0;
        end else begin
            state <= state_nxt;
            en_q  <= bus.en;
            ptr   <= ptr_nxt;
            apta  <= apta_nxt;
        end
    end

    // A start edge overrides any scan in flight; en low freezes everything but en_q.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        apta_nxt  = apta;
        if (bus.en && (start || state == ST_SCAN)) begin
            if (hit) begin
                apta_nxt  = sat;
                ptr_nxt   = (b+1)'(idx) + (b+1)'(1);
                state_nxt = (idx == bus.IBPI) ? ST_DONE : ST_SCAN;
            end else begin
                state_nxt = ST_DONE;
            end
        end
    end

    assign bus.APTA = apta;
endmodule

// File: tb/tb_aptag_case1.sv
// Directed bench for aptag_case1: vector table plus hand-written pause and reset sequences.
module tb_aptag_case1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    aptag_case1_if #(.w(16), .b(8)) bus ();

    aptag_case1 #(.w(16), .b(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         en;
        logic [16:0]  li;
        logic [255:0] data;
        logic [7:0]   ibpi;
        logic [15:0]  exp;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: APTA=%0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [16:0] li, input logic [255:0] d,
                         input logic [7:0] ibpi);
        bus.en   = en;
        bus.LI   = li;
        bus.data = d;
        bus.IBPI = ibpi;
    endtask

    initial begin
        logic [255:0] d15, dends, dmsb, dbit1, dsparse;
        d15     = 256'd15;
        dends   = 256'd1 | (256'd1 << 255);
        dmsb    = 256'd1 << 255;
        dbit1   = 256'd1 << 254;
        dsparse = (256'd1 << 252) | (256'd1 << 245);

        // Reset and idle with en low
        drive(1'b0, 17'd0, '0, 8'd0);
        #12;
        chk("reset_async", bus.APTA, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_en_low", bus.APTA, 16'd0);
        end

        // Full-range scan of bits 252..255
        tbl.push_back('{1'b1, 17'd15, d15, 8'd255, 16'd267});
        tbl.push_back('{1'b1, 17'd15, d15, 8'd255, 16'd268});
        tbl.push_back('{1'b1, 17'd15, d15, 8'd255, 16'd269});
        tbl.push_back('{1'b1, 17'd15, d15, 8'd255, 16'd270});
        tbl.push_back('{1'b1, 17'd15, d15, 8'd255, 16'd270});
        tbl.push_back('{1'b1, 17'd15, d15, 8'd255, 16'd270});
        tbl.push_back('{1'b0, 17'd15, d15, 8'd255, 16'd270});
        // IBPI=253 excludes bits 254..255
        tbl.push_back('{1'b1, 17'd15, d15, 8'd253, 16'd267});
        tbl.push_back('{1'b1, 17'd15, d15, 8'd253, 16'd268});
        tbl.push_back('{1'b1, 17'd15, d15, 8'd253, 16'd268});
        tbl.push_back('{1'b1, 17'd15, d15, 8'd253, 16'd268});
        tbl.push_back('{1'b0, 17'd15, d15, 8'd253, 16'd268});
        // Saturation: 65535+0 fits, 65535+255 clamps
        tbl.push_back('{1'b1, 17'h0FFFF, dends, 8'd255, 16'hFFFF});
        tbl.push_back('{1'b1, 17'h0FFFF, dends, 8'd255, 16'hFFFF});
        tbl.push_back('{1'b1, 17'h0FFFF, dends, 8'd255, 16'hFFFF});
        tbl.push_back('{1'b0, 17'h0FFFF, dends, 8'd255, 16'hFFFF});
        // Sparse hits at 3 and 10
        tbl.push_back('{1'b1, 17'd100, dsparse, 8'd255, 16'd103});
        tbl.push_back('{1'b1, 17'd100, dsparse, 8'd255, 16'd110});
        tbl.push_back('{1'b1, 17'd100, dsparse, 8'd255, 16'd110});
        tbl.push_back('{1'b0, 17'd100, dsparse, 8'd255, 16'd110});
        // IBPI=0 scans only data[0]
        tbl.push_back('{1'b1, 17'd5, dmsb, 8'd0, 16'd5});
        tbl.push_back('{1'b1, 17'd5, dmsb, 8'd0, 16'd5});
        tbl.push_back('{1'b0, 17'd5, dmsb, 8'd0, 16'd5});
        tbl.push_back('{1'b1, 17'd9, dbit1, 8'd0, 16'd5});
        tbl.push_back('{1'b1, 17'd9, dbit1, 8'd0, 16'd5});
        tbl.push_back('{1'b0, 17'd9, dbit1, 8'd0, 16'd5});
        // All-zero vector emits nothing
        tbl.push_back('{1'b1, 17'd40, '0, 8'd255, 16'd5});
        tbl.push_back('{1'b1, 17'd40, '0, 8'd255, 16'd5});
        tbl.push_back('{1'b0, 17'd40, '0, 8'd255, 16'd5});

        foreach (tbl[k]) begin
            drive(tbl[k].en, tbl[k].li, tbl[k].data, tbl[k].ibpi);
            step();
            chk($sformatf("vec%0d", k), bus.APTA, tbl[k].exp);
        end

        // Pause after first address, then restart from index 0
        drive(1'b1, 17'd15, d15, 8'd255);
        step();
        chk("pause_first", bus.APTA, 16'd267);
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("pause_hold", bus.APTA, 16'd267);
        end
        bus.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("pause_restart", bus.APTA, 16'(267 + i));
        end
        step();
        chk("pause_done_hold", bus.APTA, 16'd270);

        // Reset mid-scan clears immediately and stays quiet until a new en edge
        bus.en = 1'b0;
        step();
        bus.en = 1'b1;
        step();
        chk("rst_scan_first", bus.APTA, 16'd267);
        step();
        chk("rst_scan_second", bus.APTA, 16'd268);
        #2;
        rst    = 1'b1;
        bus.en = 1'b0;
        #1;
        chk("rst_immediate", bus.APTA, 16'd0);
        step();
        chk("rst_held", bus.APTA, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_quiet", bus.APTA, 16'd0);
        end
        bus.en = 1'b1;
        step();
        chk("rst_new_scan", bus.APTA, 16'd267);
        step();
        chk("rst_new_scan2", bus.APTA, 16'd268);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
